// File: rtl/pp_pkg.sv
// Shared types, default frequency limits and the saturating step helpers
// used by the push-pull frequency controller.
package pp_pkg;

  typedef enum logic [1:0] {IDLE, STEP, HOLD, REPEAT} pp_state_e;

  localparam int unsigned FREQ_MIN_DEF  = 1000;
  localparam int unsigned FREQ_MAX_DEF  = 32767;
  localparam int unsigned FREQ_INIT_DEF = 15110;

  // 17-bit sum so a step near the top of the 16-bit range cannot wrap
  function automatic logic [15:0] freq_up(input logic [15:0] work,
                                          input logic [15:0] step,
                                          input logic [15:0] fmax);
    logic [16:0] sum;
    sum = {1'b0, work} + {1'b0, step};
    return (sum > {1'b0, fmax}) ? fmax : sum[15:0];
  endfunction

  // signed difference so a step below zero clamps instead of underflowing
  function automatic logic [15:0] freq_dn(input logic [15:0] work,
                                          input logic [15:0] step,
                                          input logic [15:0] fmin);
    logic signed [17:0] diff;
    diff = $signed({2'b00, work}) - $signed({2'b00, step});
    return (diff < $signed({2'b00, fmin})) ? fmin : diff[15:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a debounce counter; the level output
// flips only after DEBOUNCE_CYC consecutive samples that disagree with it.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int unsigned     CW     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (cnt == CNT_TC) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pp_freq_ctrl.sv
// Push-pull frequency controller: two debounced buttons step a saturating
// frequency word with auto-repeat, offered to the generator over valid/ready.
//   state  | meaning
//   IDLE   | no accepted press; waiting for a lone debounced rising edge
//   STEP   | apply one step (single cycle)
//   HOLD   | button held, counting down the auto-repeat delay
//   REPEAT | button held, stepping every REPEAT_RATE_CYC cycles
module pp_freq_ctrl
  import pp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = 250000,
  parameter int unsigned REPEAT_DELAY_CYC = 12500000,
  parameter int unsigned REPEAT_RATE_CYC  = 2500000,
  parameter int unsigned FREQ_MIN         = FREQ_MIN_DEF,
  parameter int unsigned FREQ_MAX         = FREQ_MAX_DEF,
  parameter int unsigned FREQ_STEP        = 100,
  parameter int unsigned FREQ_INIT        = FREQ_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BTN_freq_UP,
  input  logic        BTN_freq_DOWN,
  output logic [15:0] cfg_freq,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic        LED_limit
);

  localparam logic [31:0] DELAY_LD = 32'(REPEAT_DELAY_CYC - 2);
  localparam logic [31:0] RATE_LD  = 32'(REPEAT_RATE_CYC - 1);
  localparam logic [15:0] F_MIN    = 16'(FREQ_MIN);
  localparam logic [15:0] F_MAX    = 16'(FREQ_MAX);
  localparam logic [15:0] F_STEP   = 16'(FREQ_STEP);
  localparam logic [15:0] F_INIT   = 16'(FREQ_INIT);

  logic        up_lvl, dn_lvl, up_prev, dn_prev;
  logic        up_rise, dn_rise, held, both;
  logic        dir_up, dir_nxt, step_en;
  logic [31:0] tmr, tmr_nxt;
  logic [15:0] work;
  pp_state_e   state, state_nxt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(BTN_freq_UP), .level(up_lvl)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .btn(BTN_freq_DOWN), .level(dn_lvl)
  );

  assign up_rise = up_lvl & ~up_prev;
  assign dn_rise = dn_lvl & ~dn_prev;
  assign held    = dir_up ? up_lvl : dn_lvl;
  assign both    = up_lvl & dn_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      dir_up  <= 1'b0;
      up_prev <= 1'b0;
      dn_prev <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmr     <= tmr_nxt;
      dir_up  <= dir_nxt;
      up_prev <= up_lvl;
      dn_prev <= dn_lvl;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    dir_nxt   = dir_up;
    step_en   = 1'b0;
    case (state)
      IDLE: begin
        // a rise while the other button is down counts as a double press
        if (up_rise && !dn_lvl) begin
          state_nxt = STEP;
          dir_nxt   = 1'b1;
        end else if (dn_rise && !up_lvl) begin
          state_nxt = STEP;
          dir_nxt   = 1'b0;
        end
      end
      STEP: begin
        step_en   = 1'b1;
        tmr_nxt   = DELAY_LD;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!held || both) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else if (tmr == '0) begin
          state_nxt = REPEAT;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      REPEAT: begin
        if (!held || both) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else if (tmr == '0) begin
          step_en = 1'b1;
          tmr_nxt = RATE_LD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= F_INIT;
      cfg_freq  <= F_INIT;
      cfg_valid <= 1'b1;
      LED_limit <= 1'b0;
    end else begin
      if (step_en) begin
        work <= dir_up ? freq_up(work, F_STEP, F_MAX) : freq_dn(work, F_STEP, F_MIN);
      end
      // a pending offer is held until accepted; later steps coalesce into one re-offer
      if (cfg_valid && cfg_ready) begin
        cfg_valid <= 1'b0;
      end else if (!cfg_valid && (work != cfg_freq)) begin
        cfg_freq  <= work;
        cfg_valid <= 1'b1;
      end
      LED_limit <= (work == F_MIN) || (work == F_MAX);
    end
  end

endmodule

// File: tb/tb_pp_freq_ctrl.sv
// Directed and randomized bench for pp_freq_ctrl; a press-level model predicts
// the frequency words the generator should receive.
module tb_pp_freq_ctrl;
  import pp_pkg::*;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int RATE = 5;
  localparam int STP  = 100;
  localparam int FMIN = 1000;
  localparam int FMAX = 32767;
  localparam int FINI = 15110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_dn;
  logic [15:0] cfg_freq;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        led_limit;

  int n_checks = 0;
  int n_errors = 0;
  int m_work;
  int got_q[$];
  int exp_q[$];

  pp_freq_ctrl #(
    .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE),
    .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .FREQ_STEP(STP), .FREQ_INIT(FINI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .BTN_freq_UP(btn_up), .BTN_freq_DOWN(btn_dn),
    .cfg_freq(cfg_freq), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .LED_limit(led_limit)
  );

  always #5 clk = ~clk;

  // inputs change at negedge+1, so this sample sees what the next posedge will see
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && cfg_valid === 1'b1 && cfg_ready === 1'b1)
      got_q.push_back(int'(cfg_freq));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // a press debounced high for d cycles: one step, then repeats starting DLY after it
  function automatic int n_steps(input int d);
    int n;
    n = 1;
    if (d - 1 >= DLY + 1) n += (d - 1 - (DLY + 1)) / RATE + 1;
    return n;
  endfunction

  task automatic model_press(input bit up, input int d, input bit push);
    int nw;
    for (int i = 0; i < n_steps(d); i++) begin
      nw = up ? ((m_work + STP > FMAX) ? FMAX : m_work + STP)
              : ((m_work - STP < FMIN) ? FMIN : m_work - STP);
      if (nw != m_work && push) exp_q.push_back(nw);
      m_work = nw;
    end
  endtask

  task automatic press(input bit up, input int h);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    tick(h);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    m_work = FINI;
    exp_q.push_back(FINI);
  endtask

  task automatic cmp_xfers(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d, nst;
    bit up;
    rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; cfg_ready = 1'b1;
    tick(3);
    chk("rst_valid", cfg_valid, 1);
    chk("rst_freq", cfg_freq, FINI);
    chk("rst_led", led_limit, 0);
    chk("rst_state", dut.state, IDLE);
    rst_n = 1'b1;
    m_work = FINI;
    exp_q.push_back(FINI);
    chk("first_valid", cfg_valid, 1);
    chk("first_freq", cfg_freq, FINI);
    tick(1);
    chk("valid_cleared", cfg_valid, 0);
    tick(5);
    cmp_xfers("init_xfer");

    press(1'b1, 10);
    model_press(1'b1, 10, 1'b1);
    cmp_xfers("up10");
    chk("up10_freq", cfg_freq, 15210);
    press(1'b1, 2);
    cmp_xfers("glitch");
    chk("glitch_freq", cfg_freq, m_work);

    do_reset();
    press(1'b1, 35);
    model_press(1'b1, 35, 1'b1);
    cmp_xfers("up_repeat");
    chk("up_repeat_freq", cfg_freq, 15510);

    cfg_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 10);
      model_press(1'b0, 10, 1'b0);
    end
    chk("stall_freq", cfg_freq, FINI);
    chk("stall_valid", cfg_valid, 1);
    chk("stall_xfers", got_q.size(), 0);
    cfg_ready = 1'b1;
    exp_q.push_back(m_work);
    tick(6);
    cmp_xfers("coalesce");
    chk("coalesce_freq", cfg_freq, 14810);

    for (int i = 0; i < 10; i++) begin
      up = 1'($urandom_range(0, 1));
      d  = int'($urandom_range(5, 50));
      press(up, d);
      model_press(up, d, 1'b1);
    end
    cmp_xfers("random");
    chk("random_freq", cfg_freq, m_work);

    nst = (FMAX - m_work) / STP + 2;
    d = DLY + 2 + RATE * nst + 10;
    press(1'b1, d);
    model_press(1'b1, d, 1'b1);
    cmp_xfers("sat_up");
    chk("sat_up_freq", cfg_freq, FMAX);
    chk("sat_up_led", led_limit, 1);
    chk("sat_up_valid", cfg_valid, 0);

    nst = (m_work - FMIN) / STP + 2;
    d = DLY + 2 + RATE * nst + 10;
    press(1'b0, d);
    model_press(1'b0, d, 1'b1);
    cmp_xfers("sat_dn");
    chk("sat_dn_freq", cfg_freq, FMIN);
    chk("sat_dn_led", led_limit, 1);

    btn_up = 1'b1;
    btn_dn = 1'b1;
    tick(15);
    chk("both_state", dut.state, IDLE);
    tick(15);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick(12);
    cmp_xfers("both");
    chk("both_freq", cfg_freq, m_work);

    btn_up = 1'b1;
    tick(30);
    chk("mid_repeat_state", dut.state, REPEAT);
    model_press(1'b1, 25, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_repeat_state", dut.state, IDLE);
    tick(3);
    rst_n = 1'b1;
    m_work = FINI;
    exp_q.push_back(FINI);
    tick(12);
    btn_up = 1'b0;
    model_press(1'b1, 12, 1'b1);
    tick(12);
    cmp_xfers("rst_repeat");
    chk("rst_repeat_freq", cfg_freq, FINI + STP);
    chk("rst_repeat_idle", dut.state, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
